bt_tx_scheduler: RTL and testbench
==================================

Name: bt_tx_scheduler

Overview:
- Round-robin scheduler sharing the single bluetooth_tx UART transmitter between two packet sources: A (stroke/drawing data) and B (chat text).
- Each packet is framed as SYNC, HEADER, payload bytes, then CHECKSUM.
- Bytes are sequenced one at a time through the transmitter's send_data_btn / finished_sending handshake.
- Sits between the source logic and bluetooth_tx; both blocks share the same clk and rst_in.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- MAX_LEN, 16, maximum payload bytes per packet; a larger requested length is clamped to this value; the legal range is 1..31.

Ports:
- clk  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- req_a  input  1  source A packet request; held high until done_a.
- len_a  input  5  source A payload length; sampled at grant.
- data_a  input  8  source A current payload byte.
- req_b  input  1  source B packet request.
- len_b  input  5  source B payload length.
- data_b  input  8  source B current payload byte.
- grant_a  output  1  high for the whole duration of source A's packet.
- grant_b  output  1  high for the whole duration of source B's packet.
- rd_a  output  1  one-cycle pulse when data_a is captured; source A then presents its next byte.
- rd_b  output  1  one-cycle pulse when data_b is captured; same rule for source B.
- done_a  output  1  one-cycle pulse when source A's packet is fully transmitted.
- done_b  output  1  one-cycle pulse when source B's packet is fully transmitted.
- tx_data  output  8  byte presented to bluetooth_tx; held stable while the byte is in flight.
- send_data_btn  output  1  send request to bluetooth_tx.
- finished_sending  input  1  one-cycle pulse from bluetooth_tx after the stop bit.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0 and state is IDLE.
  - last_grant = B, so A wins the first tie.
  - A reset mid-packet aborts immediately with no done pulse; bluetooth_tx is reset by the same rst_in.
- States: IDLE, SYNC, HDR, PAYLOAD, CSUM, DONE.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the source that is not last_grant.
  - The grant is registered: grant_x rises the cycle after req_x is seen.
  - In that same cycle: len_eff = min(len_x, MAX_LEN); src = 0 for A, 1 for B; byte count cleared; checksum cleared; next state SYNC.
- Byte launch, the common rule for every byte state:
  - On the first cycle in the state, tx_data <= byte and send_data_btn <= 1.
  - Wait for finished_sending. In that cycle, send_data_btn <= 0 and move to the next state.
  - The next byte launches on the following cycle at the earliest.
  - send_data_btn must be low when bluetooth_tx returns to IDLE, so the same byte is never sent twice.
  - finished_sending pulses that arrive while no byte is in flight are ignored.
- SYNC: byte = SYNC_BYTE; not included in the checksum. Next state HDR.
- HDR:
  - byte = {src, 2'b00, len_eff[4:0]}; checksum <= header.
  - Next state PAYLOAD, or CSUM if len_eff = 0.
- PAYLOAD:
  - At launch: tx_data <= data_x, rd_x pulses for that single cycle, checksum ^= data_x.
  - After each finished_sending, increment the count.
  - When count reaches len_eff, go to CSUM; otherwise launch the next byte.
- CSUM: byte = checksum, the XOR of header and all payload bytes. Next state DONE.
- DONE:
  - done_x pulses for one cycle; grant_x drops; last_grant <= src; return to IDLE.
  - A request still high is re-arbitrated from IDLE on the next cycle. The round-robin rule then lets a waiting other source win.
- A request dropped mid-packet is ignored: the packet completes using whatever data_x presents.
- Arbitration latency is 1 cycle from request to grant. SYNC send_data_btn rises 1 cycle after grant.
- Transmission is 3 + len_eff bytes in total.

Test Plan:
- A only, len_a=2, data 0x11 then 0x22: tx_data sequence A5, 02, 11, 22, 31; two rd_a pulses; one done_a; grant_b stays 0.
- B only, len_b=1, data 0x7F: sequence A5, 81, 7F, FE; done_b pulses once.
- req_a and req_b both high from reset, each len 1: A's packet completes first, then B's; grant_a and grant_b are never high together; on a repeat with both still high, B goes first.
- len_a=0: sequence A5, 00, 00; no rd_a pulses.
- len_a=20: header 0x10; exactly 16 payload bytes; checksum correct.
- rst_in asserted during PAYLOAD: the next cycle shows all outputs 0 and busy=0 with no done pulse; a fresh req_a then restarts with SYNC.
- Spurious finished_sending pulse while IDLE: no state change; send_data_btn is never high across two consecutive transmitter starts.

Source files
------------

// File: rtl/bt_tx_scheduler_if.sv
// Bundle of the source-side and transmitter-side signals of bt_tx_scheduler.
//
// Source A / source B : req_x, len_x, data_x  -> scheduler
//                       grant_x, rd_x, done_x <- scheduler
// Transmitter         : tx_data, send_data_btn <- scheduler
//                       finished_sending       -> scheduler
// Status              : busy                   <- scheduler
//
// master : the scheduler's view.
// slave  : the view of the surrounding logic (sources + bluetooth_tx).
interface bt_tx_scheduler_if;
    logic       req_a;
    logic [4:0] len_a;
    logic [7:0] data_a;
    logic       req_b;
    logic [4:0] len_b;
    logic [7:0] data_b;
    logic       grant_a;
    logic       grant_b;
    logic       rd_a;
    logic       rd_b;
    logic       done_a;
    logic       done_b;
    logic [7:0] tx_data;
    logic       send_data_btn;
    logic       finished_sending;
    logic       busy;

    modport master (
        input  req_a, len_a, data_a,
        input  req_b, len_b, data_b,
        input  finished_sending,
        output grant_a, grant_b, rd_a, rd_b, done_a, done_b,
        output tx_data, send_data_btn, busy
    );

    modport slave (
        output req_a, len_a, data_a,
        output req_b, len_b, data_b,
        output finished_sending,
        input  grant_a, grant_b, rd_a, rd_b, done_a, done_b,
        input  tx_data, send_data_btn, busy
    );
endinterface

// File: rtl/bt_tx_scheduler.sv
// Round-robin scheduler sharing one bluetooth_tx UART transmitter between
// source A (stroke data) and source B (chat text).
//
// Every packet goes out as: SYNC_BYTE, header, len_eff payload bytes, checksum.
//   header   = {src, 2'b00, len_eff}   (src: 0 = A, 1 = B)
//   checksum = XOR of header and all payload bytes
//   len_eff  = min(len_x, MAX_LEN), sampled when the grant is issued
//
// Ports:
//   clk     system clock, shared with bluetooth_tx
//   rst_in  synchronous active-high reset, shared with bluetooth_tx
//   bus     bt_tx_scheduler_if.master
//           req_x/len_x/data_x  source request, length, current payload byte
//           grant_x             high for the whole packet of source x
//           rd_x                one-cycle pulse when data_x was captured
//           done_x              one-cycle pulse when the packet has gone out
//           tx_data             byte to transmit, stable while in flight
//           send_data_btn       send request, held until finished_sending
//           finished_sending    one-cycle pulse from bluetooth_tx per byte
//           busy                high whenever the scheduler is not idle
module bt_tx_scheduler #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 16
) (
    input  logic               clk,
    input  logic               rst_in,
    bt_tx_scheduler_if.master  bus
);

    localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HDR,
        PAYLOAD,
        CSUM,
        DONE
    } state_t;

    state_t     state;
    logic       src;          // source of the packet in progress: 0 = A, 1 = B
    logic       last_grant;   // source served last: 0 = A, 1 = B
    logic [4:0] len_eff;
    logic [4:0] cnt;
    logic [7:0] csum;
    logic       in_flight;    // a byte has been launched and not yet finished

    logic       grant_a_r;
    logic       grant_b_r;
    logic       rd_a_r;
    logic       rd_b_r;
    logic       done_a_r;
    logic       done_b_r;
    logic [7:0] tx_data_r;
    logic       send_r;

    // Arbitration and datapath helpers
    logic       pick_valid;
    logic       pick_b;
    logic [4:0] pick_len;
    logic [4:0] pick_len_eff;
    logic [7:0] cur_data;
    logic [7:0] header;
    logic [4:0] cnt_nxt;

    always_comb begin
        pick_valid   = bus.req_a | bus.req_b;
        // With both requesting, the source that was not served last wins.
        pick_b       = bus.req_b & (~bus.req_a | ~last_grant);
        pick_len     = pick_b ? bus.len_b : bus.len_a;
        pick_len_eff = (pick_len > MAX_LEN_L) ? MAX_LEN_L : pick_len;
        cur_data     = src ? bus.data_b : bus.data_a;
        header       = {src, 2'b00, len_eff};
        cnt_nxt      = cnt + 5'd1;
    end

    // Every byte state follows the same two-phase pattern: on entry
    // (in_flight = 0) the byte is launched and send_data_btn raised; the
    // state then waits for finished_sending, drops send_data_btn and moves
    // on. Dropping send_data_btn in the finish cycle guarantees it is low
    // when bluetooth_tx is back in its idle state, so no byte is resent.
    // finished_sending seen while nothing is in flight is ignored.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= IDLE;
            src        <= 1'b0;
            last_grant <= 1'b1;
            len_eff    <= '0;
            cnt        <= '0;
            csum       <= '0;
            in_flight  <= 1'b0;
            grant_a_r  <= 1'b0;
            grant_b_r  <= 1'b0;
            rd_a_r     <= 1'b0;
            rd_b_r     <= 1'b0;
            done_a_r   <= 1'b0;
            done_b_r   <= 1'b0;
            tx_data_r  <= '0;
            send_r     <= 1'b0;
        end else begin
            rd_a_r   <= 1'b0;
            rd_b_r   <= 1'b0;
            done_a_r <= 1'b0;
            done_b_r <= 1'b0;

            case (state)
                IDLE: begin
                    in_flight <= 1'b0;
                    if (pick_valid) begin
                        src       <= pick_b;
                        grant_a_r <= ~pick_b;
                        grant_b_r <= pick_b;
                        len_eff   <= pick_len_eff;
                        cnt       <= '0;
                        csum      <= '0;
                        state     <= SYNC;
                    end
                end

                SYNC: begin
                    if (!in_flight) begin
                        tx_data_r <= SYNC_BYTE;
                        send_r    <= 1'b1;
                        in_flight <= 1'b1;
                    end else if (bus.finished_sending) begin
                        send_r    <= 1'b0;
                        in_flight <= 1'b0;
                        state     <= HDR;
                    end
                end

                HDR: begin
                    if (!in_flight) begin
                        tx_data_r <= header;
                        csum      <= header;
                        send_r    <= 1'b1;
                        in_flight <= 1'b1;
                    end else if (bus.finished_sending) begin
                        send_r    <= 1'b0;
                        in_flight <= 1'b0;
                        state     <= (len_eff == 5'd0) ? CSUM : PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (!in_flight) begin
                        tx_data_r <= cur_data;
                        csum      <= csum ^ cur_data;
                        rd_a_r    <= ~src;
                        rd_b_r    <= src;
                        send_r    <= 1'b1;
                        in_flight <= 1'b1;
                    end else if (bus.finished_sending) begin
                        send_r    <= 1'b0;
                        in_flight <= 1'b0;
                        cnt       <= cnt_nxt;
                        if (cnt_nxt == len_eff) begin
                            state <= CSUM;
                        end
                    end
                end

                CSUM: begin
                    if (!in_flight) begin
                        tx_data_r <= csum;
                        send_r    <= 1'b1;
                        in_flight <= 1'b1;
                    end else if (bus.finished_sending) begin
                        send_r    <= 1'b0;
                        in_flight <= 1'b0;
                        // done_x is high during the DONE cycle, while grant_x
                        // is still up; the source can drop req_x before IDLE
                        // re-arbitrates.
                        done_a_r  <= ~src;
                        done_b_r  <= src;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    grant_a_r  <= 1'b0;
                    grant_b_r  <= 1'b0;
                    last_grant <= src;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_a       = grant_a_r;
    assign bus.grant_b       = grant_b_r;
    assign bus.rd_a          = rd_a_r;
    assign bus.rd_b          = rd_b_r;
    assign bus.done_a        = done_a_r;
    assign bus.done_b        = done_b_r;
    assign bus.tx_data       = tx_data_r;
    assign bus.send_data_btn = send_r;
    assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_bt_tx_scheduler.sv
// Self-checking bench for bt_tx_scheduler: a bluetooth_tx model with random
// byte latency, source drivers, and a packet-level reference model.
module tb_bt_tx_scheduler;

    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;

    bt_tx_scheduler_if ifc ();

    bt_tx_scheduler #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (16)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (ifc)
    );

    logic tx_fin   = 1'b0;
    logic spur_fin = 1'b0;
    assign ifc.finished_sending = tx_fin | spur_fin;

    int vectors     = 0;
    int miscompares = 0;
    int last_grant_m = 1;          // 0 = A, 1 = B

    logic [7:0] pay_a [64];
    logic [7:0] pay_b [64];

    // ---------------- bluetooth_tx model ----------------
    logic [7:0] tx_q [$];
    logic [7:0] tx_cur;
    bit         tx_busy      = 1'b0;
    bit         send_dropped = 1'b1;
    int         tx_cnt       = 0;
    int         dup_starts   = 0;
    int         unstable     = 0;

    always @(negedge clk) begin
        tx_fin = 1'b0;
        if (rst_in === 1'b1) begin
            tx_busy      = 1'b0;
            send_dropped = 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == 0) begin
                if (ifc.tx_data !== tx_cur) unstable++;
                tx_fin  = 1'b1;
                tx_busy = 1'b0;
            end else begin
                tx_cnt--;
            end
        end else if (ifc.send_data_btn === 1'b1) begin
            if (!send_dropped) dup_starts++;
            tx_cur = ifc.tx_data;
            tx_q.push_back(ifc.tx_data);
            tx_busy      = 1'b1;
            tx_cnt       = $urandom_range(0, 3);
            send_dropped = 1'b0;
        end else begin
            send_dropped = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic fill_pay();
        for (int i = 0; i < 64; i++) begin
            pay_a[i] = 8'($urandom);
            pay_b[i] = 8'($urandom);
        end
    endtask

    // Runs na packets of source A and nb of source B (sources keep req high
    // until their last done), then checks against the reference model.
    task automatic run_packets(input int na, input int nb,
                               input logic [4:0] la, input logic [4:0] lb,
                               input bit chk_lat, input string name);
        logic [7:0] exp_q [$];
        int         exp_order [$];
        int         got_order [$];
        int         wa, wb, ia, ib, lg, s, leff, exp_rd_a, exp_rd_b, n;
        logic [7:0] hdr, cs, b;
        int         cyc, post, grant_cyc, send_cyc;
        int         rda, rdb, dna, dnb, ovl, gb_hi, da, db;

        // Reference model: round-robin order and packet bytes.
        wa = na; wb = nb; ia = 0; ib = 0; lg = last_grant_m;
        exp_rd_a = 0; exp_rd_b = 0;
        while (wa > 0 || wb > 0) begin
            if (wa > 0 && wb > 0) s = (lg == 1) ? 0 : 1;
            else                  s = (wa > 0) ? 0 : 1;
            leff = (s == 0) ? int'(la) : int'(lb);
            if (leff > 16) leff = 16;
            hdr = {s[0], 2'b00, 5'(leff)};
            exp_q.push_back(8'hA5);
            exp_q.push_back(hdr);
            cs = hdr;
            for (int k = 0; k < leff; k++) begin
                b = (s == 0) ? pay_a[ia + k] : pay_b[ib + k];
                cs ^= b;
                exp_q.push_back(b);
            end
            exp_q.push_back(cs);
            if (s == 0) begin ia += leff; wa--; exp_rd_a += leff; end
            else        begin ib += leff; wb--; exp_rd_b += leff; end
            exp_order.push_back(s);
            lg = s;
        end

        // Stimulus
        tx_q.delete();
        dup_starts = 0;
        unstable   = 0;
        da = 0; db = 0;
        ifc.len_a  = la;
        ifc.len_b  = lb;
        ifc.data_a = pay_a[0];
        ifc.data_b = pay_b[0];
        ifc.req_a  = (na > 0);
        ifc.req_b  = (nb > 0);
        cyc = 0; post = 0; grant_cyc = -1; send_cyc = -1;
        rda = 0; rdb = 0; dna = 0; dnb = 0; ovl = 0; gb_hi = 0;
        while (post < 4 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if ((ifc.grant_a || ifc.grant_b) && grant_cyc < 0) grant_cyc = cyc;
            if (ifc.send_data_btn && send_cyc < 0) send_cyc = cyc;
            if (ifc.grant_a && ifc.grant_b) ovl++;
            if (ifc.grant_b) gb_hi++;
            if (ifc.rd_a) begin
                rda++;
                if (da < 63) da++;
                ifc.data_a = pay_a[da];
            end
            if (ifc.rd_b) begin
                rdb++;
                if (db < 63) db++;
                ifc.data_b = pay_b[db];
            end
            if (ifc.done_a) begin
                dna++;
                got_order.push_back(0);
                if (dna >= na) ifc.req_a = 1'b0;
            end
            if (ifc.done_b) begin
                dnb++;
                got_order.push_back(1);
                if (dnb >= nb) ifc.req_b = 1'b0;
            end
            if (dna + dnb >= na + nb) post++;
        end
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;

        vectors++;
        if (post < 4) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d done pulses, required %0d", name, dna + dnb, na + nb);
        end
        vectors++;
        if (tx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s byte_count: got %0d, required %0d", name, tx_q.size(), exp_q.size());
        end
        n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (tx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s byte[%0d]: got %h, required %h", name, i, tx_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (rda !== exp_rd_a) begin
            miscompares++;
            $display("FAIL %s rd_a_count: got %0d, required %0d", name, rda, exp_rd_a);
        end
        vectors++;
        if (rdb !== exp_rd_b) begin
            miscompares++;
            $display("FAIL %s rd_b_count: got %0d, required %0d", name, rdb, exp_rd_b);
        end
        vectors++;
        if (dna !== na || dnb !== nb) begin
            miscompares++;
            $display("FAIL %s done_count: got A=%0d B=%0d, required A=%0d B=%0d", name, dna, dnb, na, nb);
        end
        vectors++;
        if (got_order !== exp_order) begin
            miscompares++;
            $display("FAIL %s packet_order: got %p, required %p", name, got_order, exp_order);
        end
        vectors++;
        if (ovl !== 0) begin
            miscompares++;
            $display("FAIL %s grant_overlap: got %0d cycles, required 0", name, ovl);
        end
        vectors++;
        if (dup_starts !== 0 || unstable !== 0) begin
            miscompares++;
            $display("FAIL %s tx_handshake: got dup=%0d unstable=%0d, required 0/0", name, dup_starts, unstable);
        end
        vectors++;
        if (ifc.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after: got %b, required 0", name, ifc.busy);
        end
        if (nb == 0) begin
            vectors++;
            if (gb_hi !== 0) begin
                miscompares++;
                $display("FAIL %s grant_b_idle: got %0d cycles high, required 0", name, gb_hi);
            end
        end
        if (chk_lat) begin
            vectors++;
            if (grant_cyc !== 1 || send_cyc !== 2) begin
                miscompares++;
                $display("FAIL %s latency: got grant@%0d send@%0d, required grant@1 send@2", name, grant_cyc, send_cyc);
            end
        end
        last_grant_m = lg;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in      = 1'b1;
        ifc.req_a   = 1'b0;
        ifc.req_b   = 1'b0;
        ifc.len_a   = '0;
        ifc.len_b   = '0;
        ifc.data_a  = '0;
        ifc.data_b  = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ifc.grant_a, ifc.grant_b, ifc.rd_a, ifc.rd_b, ifc.done_a, ifc.done_b,
             ifc.tx_data, ifc.send_data_btn, ifc.busy} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ga=%b gb=%b tx=%h send=%b busy=%b, required all 0",
                     ifc.grant_a, ifc.grant_b, ifc.tx_data, ifc.send_data_btn, ifc.busy);
        end
        rst_in = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ifc.busy, ifc.grant_a, ifc.grant_b, ifc.send_data_btn} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b ga=%b gb=%b send=%b, required 0",
                     ifc.busy, ifc.grant_a, ifc.grant_b, ifc.send_data_btn);
        end
        last_grant_m = 1;
    endtask

    task automatic test_a_only();
        fill_pay();
        pay_a[0] = 8'h11;
        pay_a[1] = 8'h22;
        run_packets(1, 0, 5'd2, 5'd0, 1'b1, "a_only");
    endtask

    task automatic test_b_only();
        fill_pay();
        pay_b[0] = 8'h7F;
        run_packets(0, 1, 5'd0, 5'd1, 1'b1, "b_only");
    endtask

    task automatic test_both();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        last_grant_m = 1;
        fill_pay();
        run_packets(1, 1, 5'd1, 5'd1, 1'b1, "both_from_reset");
    endtask

    task automatic test_back_to_back();
        fill_pay();
        // A keeps requesting across its done; the waiting B must win next.
        run_packets(2, 1, 5'($urandom_range(1, 6)), 5'($urandom_range(1, 6)), 1'b1, "back_to_back");
    endtask

    task automatic test_len0();
        fill_pay();
        run_packets(1, 0, 5'd0, 5'd0, 1'b1, "len_zero");
    endtask

    task automatic test_clamp();
        fill_pay();
        run_packets(1, 0, 5'd20, 5'd0, 1'b1, "clamp_20");
        fill_pay();
        run_packets(0, 1, 5'd0, 5'd31, 1'b1, "clamp_31");
    endtask

    task automatic test_random();
        int na, nb;
        for (int it = 0; it < 8; it++) begin
            fill_pay();
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 2);
            if (na == 0 && nb == 0) na = 1;
            run_packets(na, nb, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, "random");
        end
    endtask

    task automatic test_reset_midpacket();
        int cyc, rda, da, dn;
        fill_pay();
        ifc.len_a  = 5'd10;
        ifc.data_a = pay_a[0];
        ifc.req_a  = 1'b1;
        cyc = 0; rda = 0; da = 0; dn = 0;
        while (rda < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (ifc.done_a) dn++;
            if (ifc.rd_a) begin
                rda++;
                da++;
                ifc.data_a = pay_a[da];
            end
        end
        vectors++;
        if (rda < 2) begin
            miscompares++;
            $display("FAIL midreset_reach_payload: got %0d rd_a pulses, required 2", rda);
        end
        rst_in = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ifc.grant_a, ifc.grant_b, ifc.rd_a, ifc.rd_b, ifc.done_a, ifc.done_b,
             ifc.tx_data, ifc.send_data_btn, ifc.busy} !== 16'h0 || dn !== 0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ga=%b done=%b tx=%h send=%b busy=%b early_done=%0d, required all 0",
                     ifc.grant_a, ifc.done_a, ifc.tx_data, ifc.send_data_btn, ifc.busy, dn);
        end
        ifc.req_a = 1'b0;
        rst_in    = 1'b0;
        last_grant_m = 1;
        @(negedge clk);
        fill_pay();
        run_packets(1, 0, 5'd3, 5'd0, 1'b1, "restart_after_reset");
    endtask

    task automatic test_spurious();
        int bad;
        bad = 0;
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ifc.busy || ifc.send_data_btn || ifc.grant_a || ifc.grant_b) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL spurious_idle: got %0d active cycles, required 0", bad);
        end
        fill_pay();
        run_packets(1, 1, 5'($urandom_range(1, 8)), 5'($urandom_range(1, 8)), 1'b1, "after_spurious");
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_only();
        test_both();
        test_back_to_back();
        test_len0();
        test_clamp();
        test_random();
        test_reset_midpacket();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
